video_timing_gen: RTL

Parametrised raster timing generator: the successor to the fixed 720p `video_timing` block. All horizontal and vertical intervals, sync polarities and coordinate widths are parameters. The block adds line-start and frame-start strobes, a free-running frame counter, and a configurable delay line on the sync and blank outputs, so pixel sources with a multi-stage pipeline stay aligned with their coordinates. It sits in the pixel-clock domain between the PLL and the pattern or framebuffer pixel source, and drives the VGA/DVI PMOD pins.

---
 rtl/video_pkg.sv | 24 ++
 rtl/sync_delay_line.sv | 34 +++
 rtl/video_timing_gen.sv | 117 +++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared timing-mode constants and sync polarity helper for the video timing generator.
package video_pkg;

  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
  } timing_mode_t;

  localparam timing_mode_t MODE_720P    = '{1280, 110, 40, 220, 720, 5, 5, 20};
  localparam timing_mode_t MODE_640X480 = '{640, 16, 96, 48, 480, 10, 2, 33};
  localparam timing_mode_t MODE_800X600 = '{800, 40, 128, 88, 600, 1, 4, 23};

  // Map a raw "sync interval" flag onto the pin level for the given polarity.
  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// WIDTH x DEPTH shift register with synchronous reset; DEPTH=0 is a straight wire.
module sync_delay_line #(
  parameter int               WIDTH     = 3,
  parameter int               DEPTH     = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic bypass_unused;
      assign bypass_unused = clk ^ reset;
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: h/v counters, sync/blank decode, strobes,
// frame counter and an optional delay on the sync/blank outputs.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int   H_ACTIVE   = MODE_720P.h_active,
  parameter int   H_FP       = MODE_720P.h_fp,
  parameter int   H_SYNC     = MODE_720P.h_sync,
  parameter int   H_BP       = MODE_720P.h_bp,
  parameter int   V_ACTIVE   = MODE_720P.v_active,
  parameter int   V_FP       = MODE_720P.v_fp,
  parameter int   V_SYNC     = MODE_720P.v_sync,
  parameter int   V_BP       = MODE_720P.v_bp,
  parameter logic HS_POL     = 1'b1,
  parameter logic VS_POL     = 1'b1,
  parameter int   COORD_W    = 16,
  parameter int   PIPE_DELAY = 0,
  parameter int   FRAME_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               visible,
  output logic               hsync,
  output logic               vsync,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_BEGIN = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_BEGIN = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  // Cleared by reset so the first edge after release presents (0,0) rather than (1,0).
  logic               run;
  logic [COORD_W-1:0] h_next;
  logic [COORD_W-1:0] v_next;
  logic               frame_inc;
  logic [2:0]         raw_next;
  logic [2:0]         raw_dly;

  always_comb begin
    h_next    = x + COORD_W'(1);
    v_next    = y;
    frame_inc = 1'b0;
    if (!run) begin
      h_next = '0;
      v_next = '0;
    end else if (x == H_LAST) begin
      h_next = '0;
      if (y == V_LAST) begin
        v_next    = '0;
        frame_inc = 1'b1;
      end else begin
        v_next = y + COORD_W'(1);
      end
    end else begin
      h_next = x + COORD_W'(1);
    end
  end

  // Raw flags are decoded from the coordinate about to be registered, so the output
  // register keeps them aligned with x/y when the delay line is empty.
  always_comb begin
    raw_next[2] = (h_next < H_ACT) && (v_next < V_ACT);
    raw_next[1] = (h_next >= HS_BEGIN) && (h_next < HS_END);
    raw_next[0] = (v_next >= VS_BEGIN) && (v_next < VS_END);
  end

  sync_delay_line #(
    .WIDTH     (3),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL (3'b000)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .din   (raw_next),
    .dout  (raw_dly)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      run         <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      visible     <= 1'b0;
      hsync       <= sync_level(1'b0, HS_POL);
      vsync       <= sync_level(1'b0, VS_POL);
    end else begin
      run         <= 1'b1;
      x           <= h_next;
      y           <= v_next;
      line_start  <= (h_next == '0);
      frame_start <= (h_next == '0) && (v_next == '0);
      if (frame_inc) begin
        frame <= frame + FRAME_W'(1);
      end
      visible     <= raw_dly[2];
      hsync       <= sync_level(raw_dly[1], HS_POL);
      vsync       <= sync_level(raw_dly[0], VS_POL);
    end
  end

endmodule
